// File: rtl/dac_spi_pkg.sv
// Shared types and frame layout for the MCP4911-style serial DAC output stage.
// Frame: [15] channel, [14] BUF, [13] GA_n, [12] SHDN_n, [11:2] sample, [1:0] zero.
package dac_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        LDAC
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int DATA_MSB   = 11;
    localparam int DATA_LSB   = 2;
    localparam int CH_BIT     = 15;
    localparam int BUF_BIT    = 14;
    localparam int GA_BIT     = 13;
    localparam int SHDN_BIT   = 12;

    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic       buf_en,
        input logic       ga_n,
        input logic [9:0] data
    );
        logic [FRAME_BITS-1:0] w;
        w                    = '0;
        w[CH_BIT]            = 1'b0;
        w[BUF_BIT]           = buf_en;
        w[GA_BIT]            = ga_n;
        w[SHDN_BIT]          = 1'b1;
        w[DATA_MSB:DATA_LSB] = data;
        return w;
    endfunction

endpackage

// File: rtl/dac_spi_tx_sclk_tick_gen.sv
// Half-period tick source: one-cycle tick every CLK_DIV cycles,
// realigned by restart so the first tick lands CLK_DIV cycles after it.
module sclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// Serial DAC output stage: 10-bit samples framed as 16-bit SPI words (mode 0).
// Define DAC_SPI_LDAC_EN to add the post-frame LDAC latch pulse.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int GAIN_1X  = 1,
    parameter int BUFFERED = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       cs_n,
    output logic       sclk,
    output logic       mosi,
    output logic       ldac_n,
    output logic       busy
);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
        $error("dac_spi_tx: CLK_DIV must be in 1..255");
    end

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [4:0]            bit_q, bit_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  restart;
    logic                  tick;
    logic [FRAME_BITS-1:0] frame;

    assign frame = frame_word(BUFFERED != 0, GAIN_1X != 0, sample_in);

    sclk_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

`ifdef DAC_SPI_LDAC_EN
    logic ldac_q, ldac_d;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        restart = 1'b0;
`ifdef DAC_SPI_LDAC_EN
        ldac_d  = 1'b1;
`endif
        unique case (state_q)
            IDLE: begin
                if (sample_valid && sample_ready) begin
                    state_d = SETUP;
                    sr_d    = frame;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    restart = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        // falling edge: present the next bit
                        sclk_d = 1'b0;
                        sr_d   = {sr_q[FRAME_BITS-2:0], 1'b0};
                    end else if (bit_q == LAST_BIT) begin
                        state_d = GAP;
                        cs_d    = 1'b1;
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 5'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
`ifdef DAC_SPI_LDAC_EN
                    state_d = LDAC;
                    ldac_d  = 1'b0;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef DAC_SPI_LDAC_EN
            LDAC: begin
                if (tick) begin
                    state_d = IDLE;
                end else begin
                    ldac_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
        end
    end

`ifdef DAC_SPI_LDAC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ldac_q <= 1'b1;
        end else begin
            ldac_q <= ldac_d;
        end
    end

    assign ldac_n = ldac_q;
`else
    assign ldac_n = 1'b1;
`endif

    // all zeros have shifted in by frame end, so mosi idles low
    assign mosi         = sr_q[FRAME_BITS-1];
    assign cs_n         = cs_q;
    assign sclk         = sclk_q;
    assign busy         = (state_q != IDLE);
    assign sample_ready = (state_q == IDLE) && !rst;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: pin-level frame monitor with a word/timing
// model, a vector table, and hand sequences for back-to-back, streaming and reset.
module tb_dac_spi_tx;

    localparam int CD = 2;
`ifdef DAC_SPI_LDAC_EN
    localparam int RDY_LAT  = 1 + 35 * CD;
    localparam int LDAC_LEN = CD;
`else
    localparam int RDY_LAT  = 1 + 34 * CD;
    localparam int LDAC_LEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic       sample_ready, cs_n, sclk, mosi, ldac_n, busy;

    logic [9:0] s2 = '0;
    logic       v2 = 1'b0;
    logic       r2, cs2, sclk2, mosi2, ldac2, busy2;

    dac_spi_tx #(.CLK_DIV(CD), .GAIN_1X(1), .BUFFERED(0)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .ldac_n(ldac_n), .busy(busy)
    );

    dac_spi_tx #(.CLK_DIV(1), .GAIN_1X(0), .BUFFERED(1)) dut2 (
        .clk(clk), .rst(rst), .sample_in(s2),
        .sample_valid(v2), .sample_ready(r2),
        .cs_n(cs2), .sclk(sclk2), .mosi(mosi2), .ldac_n(ldac2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int model_word(int s, int ga, int bf);
        return (bf << 14) + (ga << 13) + (1 << 12) + ((s % 1024) * 4);
    endfunction

    // pin-level monitor
    int   exp_q[$];
    int   hs_log[$];
    int   word_log[$];
    int   hs_cyc = 0, fall_cyc = 0, rise_cyc = 0, mosi_chg = 0;
    int   cap = 0, rises = 0, ldac_cnt = 0, frames_done = 0, last_word = 0;
    bit   wait_ready = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_ldac = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            wait_ready = 0;
            exp_q.delete();
            rises = 0;
        end else begin
            if (wait_ready && sample_ready) begin
                chk("ready_latency", cyc - hs_cyc, RDY_LAT);
                chk("ldac_len", ldac_cnt, LDAC_LEN);
                wait_ready = 0;
            end
            if (sample_valid && sample_ready) begin
                exp_q.push_back(model_word(int'(sample_in), 1, 0));
                hs_cyc = cyc;
                hs_log.push_back(cyc);
            end
            if (prev_cs && !cs_n) begin
                chk("cs_fall_latency", cyc - hs_cyc, 1);
                fall_cyc = cyc;
                rises = 0;
                cap = 0;
                ldac_cnt = 0;
            end
            if (mosi !== prev_mosi) mosi_chg = cyc;
            if (!cs_n && sclk && !prev_sclk) begin
                cap = (cap << 1) | int'(mosi);
                rises++;
                chk("mosi_setup", (cyc - mosi_chg >= CD) ? 1 : 0, 1);
            end
            if (!ldac_n) begin
                if (prev_ldac) chk("ldac_start", cyc - rise_cyc, CD);
                ldac_cnt++;
            end
            if (!prev_cs && cs_n) begin
                chk("sclk_rises", rises, 16);
                chk("cs_low_cycles", cyc - fall_cyc, 33 * CD);
                if (exp_q.size() == 0) chk("word_expected", 0, 1);
                else chk("frame_word", cap, exp_q.pop_front());
                last_word = cap;
                word_log.push_back(cap);
                frames_done++;
                rise_cyc = cyc;
                wait_ready = 1;
            end
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_ldac = ldac_n;
    end

    task automatic send(input logic [9:0] s);
        bit got = 0;
        @(posedge clk); #1;
        sample_in = s;
        sample_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sample_ready) begin got = 1; break; end
        end
        if (!got) chk("handshake_timeout", 0, 1);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            if (frames_done >= target && !wait_ready && sample_ready) begin ok = 1; break; end
        end
        if (!ok) chk("frame_timeout", frames_done, target);
    endtask

    typedef struct {
        logic [9:0]  s;
        logic [15:0] w;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, hbase, n_stream, c2, w2, r2cnt, low2;
        bit done2;
        logic p2;

        tbl[0] = '{10'h200, 16'h3800};
        tbl[1] = '{10'h3FF, 16'h3FFC};
        tbl[2] = '{10'h001, 16'h3004};
        tbl[3] = '{10'h000, 16'h3000};
        tbl[4] = '{10'h2AA, 16'h3AA8};
        tbl[5] = '{10'(($urandom % 1024)), 16'h0};
        tbl[5].w = 16'(model_word(int'(tbl[5].s), 1, 0));

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ldac_n", ldac_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", sample_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", sample_ready, 1);

        // vector table
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].s);
            wait_done(i + 1);
            chk("tbl_word", last_word, int'(tbl[i].w));
        end

        // back-to-back: second handshake in the first ready cycle
        base = frames_done;
        hbase = hs_log.size();
        @(posedge clk); #1;
        sample_in = 10'h3FF;
        sample_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sample_ready) break;
        end
        @(posedge clk); #1;
        sample_in = 10'h001;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sample_ready) break;
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
        wait_done(base + 2);
        if (word_log.size() >= base + 2) begin
            chk("b2b_word0", word_log[base], 16'h3FFC);
            chk("b2b_word1", word_log[base + 1], 16'h3004);
        end else chk("b2b_frames", word_log.size(), base + 2);
        if (hs_log.size() >= hbase + 2)
            chk("b2b_gap", hs_log[hbase + 1] - hs_log[hbase], RDY_LAT);
        else chk("b2b_handshakes", hs_log.size(), hbase + 2);

        // continuous valid with an incrementing sample every cycle
        base = frames_done;
        hbase = hs_log.size();
        n_stream = (400 - 1) / RDY_LAT + 1;
        @(posedge clk); #1;
        for (int j = 0; j < 400; j++) begin
            sample_in = 10'(j);
            sample_valid = 1'b1;
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        wait_done(base + n_stream);
        chk("stream_handshakes", hs_log.size() - hbase, n_stream);
        for (int j = 0; j < n_stream; j++) begin
            if (word_log.size() > base + j)
                chk("stream_word", word_log[base + j], model_word(j * RDY_LAT, 1, 0));
        end

        // reset in the middle of a frame
        @(posedge clk); #1;
        sample_in = 10'h200;
        sample_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (rises == 8 && !cs_n) break;
        end
        chk("abort_reached_edge8", rises, 8);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", sample_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_release", sample_ready, 1);
        base = frames_done;
        send(10'h200);
        wait_done(base + 1);
        chk("post_abort_word", last_word, 16'h3800);

        // GAIN_1X=0, BUFFERED=1, CLK_DIV=1
        @(posedge clk); #1;
        s2 = 10'h155;
        v2 = 1'b1;
        @(negedge clk);
        chk("d2_ready", r2, 1);
        @(posedge clk); #1;
        v2 = 1'b0;
        w2 = 0; r2cnt = 0; low2 = 0; done2 = 0; p2 = 1'b0;
        for (c2 = 0; c2 < 100; c2++) begin
            @(negedge clk);
            if (!cs2) begin
                low2++;
                if (sclk2 && !p2) begin
                    w2 = (w2 << 1) | int'(mosi2);
                    r2cnt++;
                end
            end else if (low2 > 0) begin
                done2 = 1;
                break;
            end
            p2 = sclk2;
        end
        chk("d2_frame_done", int'(done2), 1);
        chk("d2_word", w2, 16'h5554);
        chk("d2_rises", r2cnt, 16);
        chk("d2_cs_low", low2, 33);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
